// File: rtl/msg_tx_if.sv
// Handshake and byte bus between the task controller, msg_tx and the UART TX.
interface msg_tx_if;
  logic       msg_req;
  logic [1:0] msg_type;
  logic [1:0] unit_code;
  logic [1:0] block_num;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       req_full;
  logic       busy;
  logic       msg_done;
  logic [7:0] drop_cnt;

  modport master (
    output msg_req, msg_type, unit_code, block_num, tx_done,
    input  tx_start, tx_data, req_full, busy, msg_done, drop_cnt
  );

  modport slave (
    input  msg_req, msg_type, unit_code, block_num, tx_done,
    output tx_start, tx_data, req_full, busy, msg_done, drop_cnt
  );
endinterface

// File: rtl/msg_tx.sv
// msg_tx: queues status-message requests and streams each as a hash-terminated
// ASCII frame to a byte-wide UART transmitter, one byte per tx_start/tx_done.
// Optional build macro MSG_TX_NEWLINE_EN appends 0x0A after '#' in every frame.
module msg_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BYTE_GAP   = 16
) (
  input  logic    clk_50M,
  input  logic    reset,
  msg_tx_if.slave bus
);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned GW       = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam int unsigned GAP_LAST = (BYTE_GAP > 0) ? BYTE_GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          empty, full, push, pop, drop;
  logic [1:0]    type_q, unit_q, blk_q;
  logic [3:0]    idx_q, idx_d, last_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    data_q, drop_q, cur_byte, u0;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = (state_q == S_LOAD);
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign push  = bus.msg_req && (!full || pop);
  assign drop  = bus.msg_req && full && !pop;

  // Queue pointers and saturating drop counter
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  // Queue storage; entries are only read after being written
  always_ff @(posedge clk_50M) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.msg_type, bus.unit_code, bus.block_num};
  end

  // FSM state, byte index, gap counter, latched message fields, held tx byte
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      type_q  <= '0;
      unit_q  <= '0;
      blk_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      if (pop) {type_q, unit_q, blk_q} <= mem_q[rd_q[AW-1:0]];
      if (state_q == S_SEND) data_q <= cur_byte;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: if (!empty) state_d = S_LOAD;
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: if (bus.tx_done) begin
        gap_d   = '0;
        state_d = (BYTE_GAP > 0) ? S_GAP : S_NEXT;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = S_NEXT;
        else                        gap_d   = gap_q + 1'b1;
      end
      S_NEXT: begin
        if (idx_q == last_idx) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SEND;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // First ASCII character of the unit name ('S','E','C','R'); second is always 'U'
  always_comb begin
    case (unit_q)
      2'd0:    u0 = 8'h53;
      2'd1:    u0 = 8'h45;
      2'd2:    u0 = 8'h43;
      default: u0 = 8'h52;
    endcase
  end

  // Frame byte at the current index and the frame's final index
  always_comb begin
    cur_byte = 8'h0A;
    last_idx = 4'd7;
    case (type_q)
      2'd0, 2'd2: begin
        last_idx = 4'd7;
        case (idx_q)
          4'd0:    cur_byte = (type_q == 2'd0) ? 8'h46 : 8'h42;
          4'd1:    cur_byte = (type_q == 2'd0) ? 8'h49 : 8'h44;
          4'd2:    cur_byte = 8'h4D;
          4'd3:    cur_byte = 8'h2D;
          4'd4:    cur_byte = u0;
          4'd5:    cur_byte = 8'h55;
          4'd6:    cur_byte = 8'h2D;
          4'd7:    cur_byte = 8'h23;
          default: cur_byte = 8'h0A;
        endcase
      end
      2'd1: begin
        last_idx = 4'd10;
        case (idx_q)
          4'd0:    cur_byte = 8'h42;
          4'd1:    cur_byte = 8'h50;
          4'd2:    cur_byte = 8'h4D;
          4'd3:    cur_byte = 8'h2D;
          4'd4:    cur_byte = u0;
          4'd5:    cur_byte = 8'h55;
          4'd6:    cur_byte = 8'h2D;
          4'd7:    cur_byte = 8'h42;
          4'd8:    cur_byte = 8'h31 + {6'd0, blk_q};
          4'd9:    cur_byte = 8'h2D;
          4'd10:   cur_byte = 8'h23;
          default: cur_byte = 8'h0A;
        endcase
      end
      default: begin
        last_idx = 4'd4;
        case (idx_q)
          4'd0:    cur_byte = 8'h45;
          4'd1:    cur_byte = 8'h4E;
          4'd2:    cur_byte = 8'h44;
          4'd3:    cur_byte = 8'h2D;
          4'd4:    cur_byte = 8'h23;
          default: cur_byte = 8'h0A;
        endcase
      end
    endcase
`ifdef MSG_TX_NEWLINE_EN
    last_idx = last_idx + 4'd1;
`endif
  end

  assign bus.tx_start = (state_q == S_SEND);
  assign bus.tx_data  = (state_q == S_SEND) ? cur_byte : data_q;
  assign bus.busy     = (state_q == S_SEND) || (state_q == S_WAIT) ||
                        (state_q == S_GAP)  || (state_q == S_NEXT);
  assign bus.msg_done = (state_q == S_DONE);
  assign bus.req_full = full;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_msg_tx.sv
// Bench for msg_tx: transaction-level reference model compared every cycle,
// plus hand-computed byte sequences and timing figures.
module tb_msg_tx;
  localparam int unsigned DEPTH = 4;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic reset;
  msg_tx_if bus ();

  msg_tx #(.FIFO_DEPTH(DEPTH), .BYTE_GAP(GAP)) dut (
    .clk_50M (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [5:0] mq [$];
  logic [7:0] cur [$];
  int   edge_n = 0;
  int   load_at = -1, send_at = -1, done_at = -1, idle_from = 0, wait_from = 0, bi = 0;
  int   pre_size;
  bit   pop_now, active = 0, waiting = 0, model_ok = 0;
  logic exp_start, exp_done, exp_busy;
  logic [7:0] exp_data, exp_drop;

  function automatic string ustr(input logic [1:0] u);
    case (u)
      2'd0:    return "SU";
      2'd1:    return "EU";
      2'd2:    return "CU";
      default: return "RU";
    endcase
  endfunction

  function automatic void frame(input logic [5:0] r);
    string s, dig;
    dig = "1234";
    case (r[5:4])
      2'd0:    s = {"FIM-", ustr(r[3:2]), "-#"};
      2'd1:    s = {"BPM-", ustr(r[3:2]), "-B", dig.substr(int'(r[1:0]), int'(r[1:0])), "-#"};
      2'd2:    s = {"BDM-", ustr(r[3:2]), "-#"};
      default: s = "END-#";
    endcase
    cur.delete();
    for (int i = 0; i < s.len(); i++) cur.push_back(s[i]);
`ifdef MSG_TX_NEWLINE_EN
    cur.push_back(8'h0A);
`endif
  endfunction

  initial begin
    exp_start = 0; exp_done = 0; exp_busy = 0; exp_data = 0; exp_drop = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        mq.delete(); cur.delete();
        active = 0; waiting = 0; load_at = -1; send_at = -1; done_at = -1;
        idle_from = edge_n + 1;
        exp_start = 0; exp_done = 0; exp_busy = 0; exp_data = 0; exp_drop = 0;
        model_ok = 1;
      end else begin
        exp_start = 0;
        exp_done  = 0;
        pre_size  = mq.size();
        pop_now   = (load_at == edge_n);
        if (pop_now) begin
          frame(mq.pop_front());
          bi = 0; send_at = edge_n; load_at = -1; exp_busy = 1;
        end
        if (waiting && edge_n >= wait_from && bus.tx_done) begin
          waiting = 0;
          if (bi == cur.size() - 1) done_at = edge_n + GAP + 1;
          else begin
            bi++;
            send_at = edge_n + GAP + 1;
          end
        end
        if (send_at == edge_n) begin
          exp_start = 1; exp_data = cur[bi];
          waiting = 1; wait_from = edge_n + 2; send_at = -1;
        end
        if (done_at == edge_n) begin
          exp_done = 1; exp_busy = 0; active = 0;
          idle_from = edge_n + 2; done_at = -1;
        end
        if (!active && edge_n >= idle_from && pre_size > 0) begin
          active = 1; load_at = edge_n + 1;
        end
        if (bus.msg_req) begin
          if (pre_size < DEPTH || pop_now)
            mq.push_back({bus.msg_type, bus.unit_code, bus.block_num});
          else if (exp_drop != 8'hFF)
            exp_drop++;
        end
      end
    end
  end

  // ---------------- compare + monitor ----------------
  logic [7:0] txlog [$];
  int   start_cycs [$];
  int   gaps [$];
  int   done_cnt = 0, done_edge = 0;
  bit   measure = 0;

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("tx_start", bus.tx_start, exp_start);
      check("tx_data",  bus.tx_data,  exp_data);
      check("busy",     bus.busy,     exp_busy);
      check("msg_done", bus.msg_done, exp_done);
      check("req_full", bus.req_full, mq.size() == DEPTH);
      check("drop_cnt", bus.drop_cnt, exp_drop);
    end
    if (bus.tx_start === 1'b1) begin
      txlog.push_back(bus.tx_data);
      if (measure) begin
        start_cycs.push_back(edge_n);
        if (start_cycs.size() > 1) gaps.push_back(edge_n - done_edge);
      end
    end
    if (bus.msg_done === 1'b1) done_cnt++;
  end

  // ---------------- UART tx_done responder ----------------
  int dn_cnt = 0;
  bit stall = 0, kick = 0, rnd_delay = 0, spur = 0;

  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (dn_cnt > 0) begin
        dn_cnt--;
        if (dn_cnt == 0) bus.tx_done = 1'b1;
      end
      if (kick) begin
        kick = 0;
        bus.tx_done = 1'b1;
      end
      if (spur && $urandom_range(0, 19) == 0) bus.tx_done = 1'b1;
      if (bus.tx_start === 1'b1 && !stall) dn_cnt = rnd_delay ? int'($urandom_range(1, 6)) : 5;
      if (bus.tx_done) done_edge = edge_n;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] exp_q [$];
  int d0, k, sz, n;

  task automatic step(input int cnt = 1);
    repeat (cnt) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_req(input logic [1:0] t, input logic [1:0] u, input logic [1:0] b);
    bus.msg_type = t; bus.unit_code = u; bus.block_num = b; bus.msg_req = 1'b1;
    step();
    bus.msg_req = 1'b0;
  endtask

  task automatic hold_req(input logic [1:0] t, input logic [1:0] u, input logic [1:0] b);
    bus.msg_type = t; bus.unit_code = u; bus.block_num = b; bus.msg_req = 1'b1;
    step();
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      step();
      c++;
    end
    check(name, done_cnt, target);
  endtask

  task automatic check_log(input string name, input logic [7:0] e [$]);
    check({name, "_len"}, txlog.size(), e.size());
    for (int i = 0; i < e.size() && i < txlog.size(); i++) check(name, txlog[i], e[i]);
  endtask

  initial begin
    reset = 1'b1;
    bus.msg_req = 1'b0; bus.msg_type = '0; bus.unit_code = '0; bus.block_num = '0;
    step(3);
    reset = 1'b0;
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data",  bus.tx_data,  0);
    check("rst_busy",     bus.busy,     0);
    check("rst_msg_done", bus.msg_done, 0);
    check("rst_req_full", bus.req_full, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);

    // FIM from EU
    txlog.delete(); d0 = done_cnt;
    send_req(2'd0, 2'd1, 2'd0);
    wait_done(d0 + 1, 400, "t1_done");
    step(3);
    exp_q = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h45, 8'h55, 8'h2D, 8'h23};
`ifdef MSG_TX_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
    check_log("t1_bytes", exp_q);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_busy_after", bus.busy, 0);

    // BPM SU block 3: latency and inter-byte gap
    txlog.delete(); start_cycs.delete(); gaps.delete(); d0 = done_cnt;
    measure = 1; k = edge_n;
    send_req(2'd1, 2'd0, 2'd2);
    wait_done(d0 + 1, 500, "t2_done");
    measure = 0;
    step(3);
    exp_q = '{8'h42, 8'h50, 8'h4D, 8'h2D, 8'h53, 8'h55, 8'h2D, 8'h42, 8'h33, 8'h2D, 8'h23};
`ifdef MSG_TX_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
    check_log("t2_bytes", exp_q);
    check("t2_latency", (start_cycs.size() > 0) ? start_cycs[0] - k : -1, 3);
    check("t2_gap_count", gaps.size(), exp_q.size() - 1);
    foreach (gaps[i]) check("t2_gap", gaps[i], 18);

    // spurious tx_done while idle
    sz = txlog.size(); d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      kick = 1;
      step(7);
    end
    step(20);
    check("idle_spur_tx", txlog.size(), sz);
    check("idle_spur_done", done_cnt, d0);
    check("idle_spur_busy", bus.busy, 0);

    // burst of six requests with the UART stalled
    stall = 1; txlog.delete(); d0 = done_cnt;
    hold_req(2'd3, 2'd0, 2'd0);
    hold_req(2'd0, 2'd2, 2'd0);
    hold_req(2'd2, 2'd3, 2'd0);
    hold_req(2'd1, 2'd1, 2'd3);
    hold_req(2'd0, 2'd0, 2'd0);
    hold_req(2'd2, 2'd1, 2'd0);
    bus.msg_req = 1'b0;
    check("t3_req_full", bus.req_full, 1);
    check("t3_drop_cnt", bus.drop_cnt, 1);
    step(10);
    check("t3_stalled_bytes", txlog.size(), 1);
    stall = 0; kick = 1;
    wait_done(d0 + 5, 3000, "t3_done");
    step(5);
`ifdef MSG_TX_NEWLINE_EN
    check("t3_total_bytes", txlog.size(), 45);
`else
    check("t3_total_bytes", txlog.size(), 40);
`endif
    check("t3_full_after", bus.req_full, 0);

    // reset during byte 3 of a BDM
    txlog.delete(); n = 0;
    send_req(2'd2, 2'd2, 2'd0);
    while (txlog.size() < 3 && n < 300) begin
      step();
      n++;
    end
    check("t4_reach_byte3", txlog.size(), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_tx_start", bus.tx_start, 0);
    check("t4_tx_data",  bus.tx_data,  0);
    check("t4_busy",     bus.busy,     0);
    check("t4_msg_done", bus.msg_done, 0);
    check("t4_drop_cnt", bus.drop_cnt, 0);
    sz = txlog.size(); d0 = done_cnt;
    step(25);
    check("t4_no_tx", txlog.size(), sz);
    check("t4_no_done", done_cnt, d0);
    txlog.delete();
    send_req(2'd3, 2'd2, 2'd1);
    wait_done(d0 + 1, 300, "t4_end_done");
    step(3);
    exp_q = '{8'h45, 8'h4E, 8'h44, 8'h2D, 8'h23};
`ifdef MSG_TX_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
    check_log("t4_end_bytes", exp_q);

    // randomized traffic, random UART delay, spurious tx_done, one mid-run reset
    rnd_delay = 1; spur = 1;
    for (int i = 0; i < 800; i++) begin
      bus.msg_req   = ($urandom_range(0, 9) == 0);
      bus.msg_type  = 2'($urandom_range(0, 3));
      bus.unit_code = 2'($urandom_range(0, 3));
      bus.block_num = 2'($urandom_range(0, 3));
      reset = (i == 400);
      step();
    end
    reset = 1'b0; bus.msg_req = 1'b0; spur = 0;
    n = 0;
    while ((mq.size() != 0 || active) && n < 8000) begin
      step();
      n++;
    end
    check("rand_drained", (mq.size() == 0 && !active), 1);
    step(5);
    check("rand_busy_end", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
